// File: rtl/noisy_channel_if.sv
// noisy_channel_if
//   Stream bundle around the error-injecting channel.
//   master : upstream/downstream side (drives in_valid, data_in, out_ready)
//   slave  : the channel itself (drives in_ready, out_valid, data_out, err_mask)
//   Codeword vectors are [0:WIDTH-1]; index 0 is the MSB-side bit.
interface noisy_channel_if #(
   parameter int unsigned WIDTH = 9
);
   logic               in_valid;
   logic               in_ready;
   logic [0:WIDTH-1]   data_in;
   logic               out_valid;
   logic               out_ready;
   logic [0:WIDTH-1]   data_out;
   logic [0:WIDTH-1]   err_mask;

   modport master (
      output in_valid, data_in, out_ready,
      input  in_ready, out_valid, data_out, err_mask
   );

   modport slave (
      input  in_valid, data_in, out_ready,
      output in_ready, out_valid, data_out, err_mask
   );
endinterface

// File: rtl/noisy_channel.sv
// noisy_channel
//   Registered error-injecting channel for ECC codeword experiments. Each
//   accepted codeword gets 0, 1 or 2 bit flips at positions derived from a
//   reseedable 16-bit Galois LFSR, with one output register (latency 1).
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   mode       0 = pass, 1 = single flip, 2 = double flip, 3 = pass
//   seed_load  load seed_in into the LFSR (0 is loaded as 16'h0001)
//   seed_in    new LFSR value
//   bus        stream interface (slave): in_valid/in_ready/data_in,
//              out_valid/out_ready/data_out/err_mask
//   err_count  words accepted with a nonzero mask, saturating at 16'hFFFF
module noisy_channel #(
   parameter int unsigned WIDTH = 9,
   parameter logic [15:0] SEED  = 16'hACE1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [1:0]          mode,
   input  logic                seed_load,
   input  logic [15:0]         seed_in,
   noisy_channel_if.slave      bus,
   output logic [15:0]         err_count
);

   // The all-zero LFSR state is a lock-up state; never enter it.
   localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
   localparam logic [8:0]  W_MOD    = 9'(WIDTH);
   localparam logic [8:0]  W_MOD_M1 = 9'(WIDTH - 1);
   localparam logic [15:0] TAPS     = 16'hB400;

   logic [15:0]        lfsr_q;
   logic [15:0]        lfsr_next;
   logic [15:0]        err_cnt_q;
   logic               out_valid_q;
   logic [0:WIDTH-1]   data_q;
   logic [0:WIDTH-1]   mask_q;
   logic [0:WIDTH-1]   mask;
   logic [8:0]         p1;
   logic [8:0]         p2;
   logic               flip;
   logic               xfer;

   assign bus.in_ready  = !out_valid_q || bus.out_ready;
   assign xfer          = bus.in_valid && bus.in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.data_out  = data_q;
   assign bus.err_mask  = mask_q;
   assign err_count     = err_cnt_q;

   assign flip      = (mode == 2'd1) || (mode == 2'd2);
   assign lfsr_next = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : 16'h0000);

   // p2 is offset from p1 by 1..WIDTH-1 (mod WIDTH), so it never equals p1.
   always_comb begin
      p1   = {1'b0, lfsr_q[7:0]} % W_MOD;
      p2   = (p1 + 9'd1 + ({1'b0, lfsr_q[15:8]} % W_MOD_M1)) % W_MOD;
      mask = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (mode == 2'd1) begin
            mask[i] = (9'(i) == p1);
         end else if (mode == 2'd2) begin
            mask[i] = (9'(i) == p1) || (9'(i) == p2);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q      <= SEED_EFF;
         out_valid_q <= 1'b0;
         data_q      <= '0;
         mask_q      <= '0;
         err_cnt_q   <= '0;
      end else begin
         if (xfer) begin
            data_q      <= bus.data_in ^ mask;
            mask_q      <= mask;
            out_valid_q <= 1'b1;
            if ((|mask) && (err_cnt_q != '1)) begin
               err_cnt_q <= err_cnt_q + 16'd1;
            end
         end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
         end

         // A coincident xfer already used the old value for its mask;
         // the seed wins over the advance.
         if (seed_load) begin
            lfsr_q <= (seed_in == 16'h0000) ? 16'h0001 : seed_in;
         end else if (xfer && flip) begin
            lfsr_q <= lfsr_next;
         end
      end
   end

endmodule

// File: tb/tb_noisy_channel.sv
// tb_noisy_channel
//   Directed bench for noisy_channel (WIDTH=9, SEED=16'h0001). Inputs are
//   driven and outputs sampled 1 time unit after the rising edge.
module tb_noisy_channel;

   localparam int unsigned W = 9;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  mode;
   logic        seed_load;
   logic [15:0] seed_in;
   logic [15:0] err_count;

   int unsigned checks = 0;
   int unsigned errors = 0;

   noisy_channel_if #(.WIDTH(W)) bus ();

   noisy_channel #(.WIDTH(W), .SEED(16'h0001)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .seed_load (seed_load),
      .seed_in   (seed_in),
      .bus       (bus.master),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] m, input logic [8:0] d);
      mode         = m;
      bus.data_in  = d;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
   endtask

   task automatic do_reset();
      bus.in_valid = 1'b0;
      rst_n        = 1'b0;
      step();
      step();
      rst_n        = 1'b1;
   endtask

   task automatic load_seed(input logic [15:0] s);
      seed_in   = s;
      seed_load = 1'b1;
      step();
      seed_load = 1'b0;
   endtask

   task automatic check_out(input string tag, input logic [31:0] d, input logic [31:0] m);
      check_val({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      check_val({tag, "_data"},  32'(bus.data_out),  d);
      check_val({tag, "_mask"},  32'(bus.err_mask),  m);
   endtask

   initial begin
      rst_n         = 1'b0;
      mode          = 2'd0;
      seed_load     = 1'b0;
      seed_in       = 16'h0000;
      bus.in_valid  = 1'b0;
      bus.data_in   = '0;
      bus.out_ready = 1'b1;

      // T1: reset state and first word
      do_reset();
      check_val("rst_valid", 32'(bus.out_valid), 32'd0);
      check_val("rst_ready", 32'(bus.in_ready),  32'd1);
      check_val("rst_data",  32'(bus.data_out),  32'h000);
      check_val("rst_mask",  32'(bus.err_mask),  32'h000);
      check_val("rst_cnt",   32'(err_count),     32'd0);
      check_val("rst_lfsr",  32'(dut.lfsr_q),    32'h0001);
      send(2'd1, 9'h000);
      check_out("t1_first", 32'h080, 32'h080);
      check_val("t1_cnt", 32'(err_count), 32'd1);

      // T1: async reset while a word is held
      bus.out_ready = 1'b0;
      send(2'd1, 9'h155);
      check_val("t1_held", 32'(bus.out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_val("t1_arst_valid", 32'(bus.out_valid), 32'd0);
      check_val("t1_arst_ready", 32'(bus.in_ready),  32'd1);
      check_val("t1_arst_cnt",   32'(err_count),     32'd0);
      check_val("t1_arst_data",  32'(bus.data_out),  32'h000);
      bus.out_ready = 1'b1;
      step();
      rst_n = 1'b1;

      // T2: single-bit flips
      load_seed(16'h0001);
      send(2'd1, 9'h000);
      check_out("t2_w0", 32'h080, 32'h080);
      check_val("t2_lfsr", 32'(dut.lfsr_q), 32'hB400);
      send(2'd1, 9'h1FF);
      check_out("t2_w1", 32'h0FF, 32'h100);

      // T3: double-bit flips
      do_reset();
      load_seed(16'h0001);
      send(2'd2, 9'h000);
      check_out("t3_w0", 32'h0C0, 32'h0C0);
      send(2'd2, 9'h000);
      check_out("t3_w1", 32'h108, 32'h108);
      check_val("t3_cnt",  32'(err_count),  32'd2);
      check_val("t3_lfsr", 32'(dut.lfsr_q), 32'h5A00);

      // T4: backpressure
      do_reset();
      bus.out_ready = 1'b0;
      send(2'd1, 9'h155);
      bus.in_valid = 1'b1;
      bus.data_in  = 9'h01E;
      for (int i = 0; i < 5; i++) begin
         check_val("t4_ready", 32'(bus.in_ready), 32'd0);
         check_out("t4_hold", 32'h1D5, 32'h080);
         check_val("t4_lfsr", 32'(dut.lfsr_q), 32'hB400);
         step();
      end
      bus.out_ready = 1'b1;
      #1;
      check_val("t4_release_ready", 32'(bus.in_ready), 32'd1);
      step();
      bus.in_valid = 1'b0;
      check_out("t4_next", 32'h11E, 32'h100);
      step();
      check_val("t4_drain_valid", 32'(bus.out_valid), 32'd0);
      check_val("t4_drain_data",  32'(bus.data_out),  32'h11E);
      check_val("t4_cnt",         32'(err_count),     32'd2);

      // T5: pass modes leave count and LFSR untouched
      send(2'd0, 9'h199);
      check_out("t5_m0", 32'h199, 32'h000);
      send(2'd3, 9'h066);
      check_out("t5_m3", 32'h066, 32'h000);
      check_val("t5_cnt",  32'(err_count),  32'd2);
      check_val("t5_lfsr", 32'(dut.lfsr_q), 32'h5A00);

      // T5: seed_load coinciding with a transfer
      seed_in   = 16'h1234;
      seed_load = 1'b1;
      send(2'd1, 9'h000);
      seed_load = 1'b0;
      check_out("t5_coll", 32'h100, 32'h100);
      check_val("t5_coll_lfsr", 32'(dut.lfsr_q), 32'h1234);
      send(2'd2, 9'h000);
      check_out("t5_seeded", 32'h082, 32'h082);
      check_val("t5_cnt2", 32'(err_count), 32'd4);

      // T6: counter saturation
      do_reset();
      mode         = 2'd1;
      bus.data_in  = 9'h000;
      bus.in_valid = 1'b1;
      repeat (65534) @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check_val("t6_pre", 32'(err_count), 32'hFFFE);
      for (int i = 0; i < 3; i++) begin
         send(2'd1, 9'h000);
         check_val("t6_sat", 32'(err_count), 32'hFFFF);
      end

      // T6: zero seed is replaced by 1
      load_seed(16'h0000);
      check_val("t6_zero_seed", 32'(dut.lfsr_q), 32'h0001);
      send(2'd1, 9'h000);
      check_out("t6_after_seed", 32'h080, 32'h080);

      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
